sar_search: RTL and testbench

Successive-approximation search controller that drives the `y` operand of the team's combinational N-bit magnitude comparator and consumes its one-hot `comp` code. It sits on the initiator side of that comparator and finds an unknown `x` by binary search, MSB first. The search exits early on equality. Used wherever a value is only observable through compare results (threshold trimming, SAR-style conversion).

---
 rtl/sar_search_pkg.sv | 23 ++
 rtl/sar_search.sv | 145 ++++++++++++++
 tb/tb_sar_search.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/sar_search_pkg.sv
// Shared definitions for the successive-approximation search controller.
//   - comparator result codes (one-hot, {gt, eq, lt})
//   - controller state enum
//   - index-width helper: ceil(log2(n)), never less than 1
package sar_search_pkg;

  localparam logic [2:0] CMP_GT = 3'b100;  // x > y
  localparam logic [2:0] CMP_EQ = 3'b010;  // x == y
  localparam logic [2:0] CMP_LT = 3'b001;  // x < y

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StSearch = 1'b1
  } state_e;

  // A 1-bit operand still needs a 1-bit index register.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sar_search.sv
// Successive-approximation search controller. Drives the y operand of an external
// magnitude comparator and finds x by MSB-first binary search, exiting early on equality.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset
//   start  - request a new search (only accepted while idle)
//   comp   - comparator code for x vs. guess: 100 gt, 010 eq, 001 lt, else illegal
//   guess  - trial value for the comparator's y operand (0 while idle)
//   busy   - high while a search is in progress
//   done   - one-cycle pulse when result/err update
//   result - found value, held until the next accepted start
//   err    - last search aborted on an illegal comp code
module sar_search
  import sar_search_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   comp,
  output logic [N-1:0] guess,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         err
);

  localparam int unsigned IdxW = idx_width(N);
  localparam logic [N-1:0] One = N'(1);
  localparam logic [N-1:0] Msb = One << (N - 1);
  localparam logic [IdxW-1:0] IdxTop = IdxW'(N - 1);

  state_e          state_q, state_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [N-1:0]    guess_q, guess_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [N-1:0]    result_q, result_d;
  logic            err_q, err_d;

  // Accumulator after this cycle's keep/drop decision.
  logic [N-1:0]    acc_upd;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    guess_d  = guess_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    err_d    = err_q;
    acc_upd  = acc_q;

    unique case (state_q)
      StIdle: begin
        guess_d = '0;
        busy_d  = 1'b0;
        if (start) begin
          state_d  = StSearch;
          acc_d    = '0;
          idx_d    = IdxTop;
          guess_d  = Msb;
          busy_d   = 1'b1;
          result_d = '0;
          err_d    = 1'b0;
        end
      end

      StSearch: begin
        unique case (comp)
          CMP_EQ: begin
            result_d = guess_q;
            done_d   = 1'b1;
            state_d  = StIdle;
            busy_d   = 1'b0;
            guess_d  = '0;
          end
          CMP_GT, CMP_LT: begin
            // Keep the trial bit only if x is still above the guess.
            acc_upd = (comp == CMP_GT) ? guess_q : acc_q;
            acc_d   = acc_upd;
            if (idx_q == '0) begin
              result_d = acc_upd;
              done_d   = 1'b1;
              state_d  = StIdle;
              busy_d   = 1'b0;
              guess_d  = '0;
            end else begin
              idx_d   = idx_q - 1'b1;
              guess_d = acc_upd | (One << (idx_q - 1'b1));
            end
          end
          default: begin
            // Anything not exactly one-hot aborts with the bits accepted so far.
            result_d = acc_q;
            err_d    = 1'b1;
            done_d   = 1'b1;
            state_d  = StIdle;
            busy_d   = 1'b0;
            guess_d  = '0;
          end
        endcase
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        guess_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      idx_q    <= '0;
      guess_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      guess_q  <= guess_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign guess  = guess_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: an N=4 and an N=8 instance, each paired with a
// behavioural comparator. Expected results come from the target value itself; the
// expected number of search cycles is N minus the count of trailing zeros of x
// (N for x = 0), since equality is hit as soon as every set bit has been tried.
module tb_sar_search;
  import sar_search_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // N = 4 instance
  logic       start4 = 1'b0;
  logic [3:0] x4 = '0;
  logic [2:0] comp4;
  logic [3:0] guess4, result4;
  logic       busy4, done4, err4;
  logic       force4 = 1'b0;
  logic [2:0] force_code = 3'b111;

  // N = 8 instance
  logic       start8 = 1'b0;
  logic [7:0] x8 = '0;
  logic [2:0] comp8;
  logic [7:0] guess8, result8;
  logic       busy8, done8, err8;

  function automatic logic [2:0] cmp(input logic [7:0] x, input logic [7:0] y);
    if (x > y) return 3'b100;
    if (x == y) return 3'b010;
    return 3'b001;
  endfunction

  assign comp4 = force4 ? force_code : cmp({4'b0, x4}, {4'b0, guess4});
  assign comp8 = cmp(x8, guess8);

  sar_search #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .comp(comp4),
    .guess(guess4), .busy(busy4), .done(done4), .result(result4), .err(err4)
  );

  sar_search #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .comp(comp8),
    .guess(guess8), .busy(busy8), .done(done8), .result(result8), .err(err8)
  );

  // Selected-instance view so the tasks serve both widths.
  bit         wide_sel = 1'b0;
  logic [7:0] guess_w, result_w;
  logic       busy_w, done_w, err_w;
  assign guess_w  = wide_sel ? guess8  : {4'b0, guess4};
  assign result_w = wide_sel ? result8 : {4'b0, result4};
  assign busy_w   = wide_sel ? busy8   : busy4;
  assign done_w   = wide_sel ? done8   : done4;
  assign err_w    = wide_sel ? err8    : err4;

  int n_cmp  = 0;
  int n_fail = 0;
  int guesses[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_cycles(input logic [7:0] x, input int n);
    int tz;
    if (x == 0) return n;
    tz = 0;
    while (x[tz] == 1'b0) tz++;
    return n - tz;
  endfunction

  // Drives start for one edge (or leaves it high if hold), then checks the search began.
  task automatic begin_search(input bit wide, input logic [7:0] x, input bit hold);
    wide_sel = wide;
    if (wide) begin
      x8 = x;
      start8 = 1'b1;
    end else begin
      x4 = x[3:0];
      start4 = 1'b1;
    end
    @(negedge clk);
    if (!hold) begin
      start4 = 1'b0;
      start8 = 1'b0;
    end
    check("busy_after_start", busy_w, 1);
    check("first_guess", guess_w, wide ? 8'h80 : 8'h08);
    check("err_cleared", err_w, 0);
    check("result_cleared", result_w, 0);
  endtask

  // Steps search cycles until done, recording guesses; bounded at 20 cycles.
  task automatic wait_done(output int cycles);
    guesses.delete();
    cycles = 0;
    while (!done_w && cycles < 20) begin
      guesses.push_back(int'(guess_w));
      check("busy_during_search", busy_w, 1);
      @(negedge clk);
      cycles++;
    end
    check("done_seen", done_w, 1);
    check("busy_low_at_done", busy_w, 0);
    check("guess_zero_at_done", guess_w, 0);
  endtask

  task automatic full_search(input bit wide, input logic [7:0] x);
    int c;
    begin_search(wide, x, 1'b0);
    wait_done(c);
    check("sweep_result", result_w, x);
    check("sweep_err", err_w, 0);
    check("sweep_cycles", c, exp_cycles(x, wide ? 8 : 4));
  endtask

  initial begin
    int c;
    int exp_a[4];
    int exp_b[4];

    // Reset values
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_guess", guess4, 0);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_result", result4, 0);
    check("rst_err", err4, 0);
    rst = 1'b0;
    @(negedge clk);

    // x = 11: guesses 8, 12, 10, 11
    exp_a = '{8, 12, 10, 11};
    begin_search(1'b0, 8'd11, 1'b0);
    wait_done(c);
    check("x11_cycles", c, 4);
    check("x11_nguess", guesses.size(), 4);
    for (int i = 0; i < 4 && i < guesses.size(); i++) check("x11_guess", guesses[i], exp_a[i]);
    check("x11_result", result4, 11);
    check("x11_err", err4, 0);
    @(negedge clk);
    check("done_one_cycle", done4, 0);
    check("result_held", result4, 11);

    // x = 0: guesses 8, 4, 2, 1
    exp_b = '{8, 4, 2, 1};
    begin_search(1'b0, 8'd0, 1'b0);
    wait_done(c);
    check("x0_cycles", c, 4);
    for (int i = 0; i < 4 && i < guesses.size(); i++) check("x0_guess", guesses[i], exp_b[i]);
    check("x0_result", result4, 0);

    // x = 8: immediate equality, busy for exactly one cycle
    begin_search(1'b0, 8'd8, 1'b0);
    wait_done(c);
    check("x8_cycles", c, 1);
    check("x8_result", result4, 8);

    // Illegal code on the 2nd search cycle with x = 13
    begin_search(1'b0, 8'd13, 1'b0);
    @(negedge clk);
    check("err_guess2", guess4, 12);
    force_code = 3'b111;
    force4 = 1'b1;
    @(negedge clk);
    force4 = 1'b0;
    check("err_done", done4, 1);
    check("err_flag", err4, 1);
    check("err_result", result4, 8);
    check("err_busy", busy4, 0);
    // Illegal code while idle must not raise err
    force_code = 3'b000;
    force4 = 1'b1;
    @(negedge clk);
    check("idle_comp_ignored", err4, 1);
    check("idle_no_done", done4, 0);
    force4 = 1'b0;
    begin_search(1'b0, 8'd13, 1'b0);
    wait_done(c);
    check("x13_result", result4, 13);
    check("x13_err", err4, 0);

    // Reset on the 3rd search cycle
    begin_search(1'b0, 8'd11, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_guess", guess4, 0);
    check("mid_rst_busy", busy4, 0);
    check("mid_rst_done", done4, 0);
    check("mid_rst_result", result4, 0);
    check("mid_rst_err", err4, 0);
    @(negedge clk);
    check("mid_rst_no_done", done4, 0);

    // start held high during busy is ignored; dropped in the done cycle
    begin_search(1'b0, 8'd6, 1'b1);
    wait_done(c);
    start4 = 1'b0;
    check("hold_cycles", c, 3);
    check("hold_result", result4, 6);
    @(negedge clk);
    check("hold_idle_after", busy4, 0);

    // Back-to-back: start in the done cycle
    begin_search(1'b0, 8'd11, 1'b0);
    wait_done(c);
    check("b2b_first_result", result4, 11);
    begin_search(1'b0, 8'd5, 1'b0);
    wait_done(c);
    check("b2b_second_result", result4, 5);
    check("b2b_second_cycles", c, 4);

    // Exhaustive sweep for N = 4
    for (int x = 0; x < 16; x++) full_search(1'b0, 8'(x));

    // N = 8: edges plus random targets
    full_search(1'b1, 8'd0);
    full_search(1'b1, 8'd255);
    full_search(1'b1, 8'd128);
    for (int i = 0; i < 24; i++) full_search(1'b1, 8'($urandom_range(0, 255)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
